// File: rtl/gol_pkg.sv
// gol_pkg: shared Game-of-Life types and constants.
// Used by the window streamer and the next-state logic.
package gol_pkg;

  localparam int GOL_WORD_W = 16;
  localparam int GOL_WIDTH  = 640;
  localparam int GOL_HEIGHT = 480;

  // 3x3 neighbourhood, bit dy*3+dx
  typedef logic [8:0] win_t;

  localparam int WIN_N      = 1;
  localparam int WIN_W      = 3;
  localparam int WIN_CENTRE = 4;
  localparam int WIN_E      = 5;
  localparam int WIN_S      = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_EMIT,
    S_ADVANCE,
    S_LOAD,
    S_FINISH
  } gws_state_t;

endpackage

// File: rtl/gol_row_loader.sv
// gol_row_loader: issues WPR sequential word reads for one grid row
// and assembles the returned words into a WIDTH-bit row.
// Ports: clk, reset (sync, active high), go/row (start a row fetch),
// mem_en/mem_addr/mem_rdata (RAM read port, 1-cycle latency),
// last_issue (final read of the row is on the bus this cycle),
// row_done (final word arrives this cycle), row_out (row incl. that word).
module gol_row_loader
  import gol_pkg::*;
#(
  parameter int WIDTH  = GOL_WIDTH,
  parameter int WORD_W = GOL_WORD_W,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W-1:0] row,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              last_issue,
  output logic              row_done,
  output logic [WIDTH-1:0]  row_out
);

  localparam int WPR = WIDTH / WORD_W;
  localparam int WW  = (WPR > 1) ? $clog2(WPR) : 1;

  logic [WW-1:0]    word;
  logic [WW-1:0]    cap_word;
  logic             cap_valid;
  logic [WIDTH-1:0] row_q;

  assign last_issue = mem_en && (word == WW'(WPR - 1));
  assign row_done   = cap_valid && (cap_word == WW'(WPR - 1));

  // Merge the word arriving this cycle so the owner can take the
  // complete row on the same edge the last word lands.
  always_comb begin
    row_out = row_q;
    if (cap_valid) begin
      row_out[int'(cap_word)*WORD_W +: WORD_W] = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      word      <= '0;
      cap_valid <= 1'b0;
      cap_word  <= '0;
      row_q     <= '0;
    end else begin
      cap_valid <= mem_en;
      cap_word  <= word;
      row_q     <= row_out;
      // go wins over the running fetch so two rows can be
      // fetched back to back without a bubble.
      if (go) begin
        mem_en   <= 1'b1;
        mem_addr <= row * ADDR_W'(WPR);
        word     <= '0;
      end else if (mem_en) begin
        if (last_issue) begin
          mem_en <= 1'b0;
        end else begin
          word     <= word + 1'b1;
          mem_addr <= mem_addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gol_window_streamer.sv
// gol_window_streamer: sweeps the packed grid RAM and streams one
// 3x3 window per cell in raster order over a valid/ready interface.
// Ports: clk, reset (sync, active high), start/busy/done (frame
// control), mem_en/mem_addr/mem_rdata (RAM read port), win_valid/
// win_ready/win_data/win_x/win_y/win_last (window stream).
module gol_window_streamer
  import gol_pkg::*;
#(
  parameter int WIDTH  = GOL_WIDTH,
  parameter int HEIGHT = GOL_HEIGHT,
  parameter int WORD_W = GOL_WORD_W,
  parameter int ADDR_W = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [WORD_W-1:0]         mem_rdata,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [8:0]                win_data,
  output logic [$clog2(WIDTH)-1:0]  win_x,
  output logic [$clog2(HEIGHT)-1:0] win_y,
  output logic                      win_last
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  gws_state_t state;

  logic [WIDTH-1:0]  above;
  logic [WIDTH-1:0]  cur;
  logic [WIDTH-1:0]  below;
  logic [WIDTH-1:0]  row_out;
  logic [ADDR_W-1:0] ld_row;
  logic [ADDR_W-1:0] go_row;
  logic              kick;
  logic              pend;
  logic              prime_cnt;
  logic              chain_go;
  logic              go;
  logic              ld_last;
  logic              row_done;
  logic              x_last;
  logic              y_last;
  logic              more_rows;
  logic [WIDTH+1:0]  sh_a;
  logic [WIDTH+1:0]  sh_c;
  logic [WIDTH+1:0]  sh_b;

  // Row 1 is chained onto row 0 during priming so mem_en
  // stays high for 2*WPR consecutive cycles.
  assign chain_go = (state == S_PRIME) && pend && ld_last;
  assign go       = kick | chain_go;
  assign go_row   = chain_go ? ADDR_W'(1) : ld_row;

  assign x_last    = (win_x == XW'(WIDTH - 1));
  assign y_last    = (win_y == YW'(HEIGHT - 1));
  assign more_rows = (int'(win_y) + 2) < HEIGHT;
  assign win_last  = win_valid && x_last && y_last;

  gol_row_loader #(
    .WIDTH  (WIDTH),
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_loader (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .row        (go_row),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .last_issue (ld_last),
    .row_done   (row_done),
    .row_out    (row_out)
  );

  // Zero padding on both ends supplies the out-of-grid columns;
  // after the shift bits [2:0] are columns x-1..x+1.
  always_comb begin
    sh_a = {1'b0, above, 1'b0} >> win_x;
    sh_c = {1'b0, cur,   1'b0} >> win_x;
    sh_b = {1'b0, below, 1'b0} >> win_x;
    win_data = {sh_b[2:0], sh_c[2:0], sh_a[2:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      win_valid <= 1'b0;
      win_x     <= '0;
      win_y     <= '0;
      above     <= '0;
      cur       <= '0;
      below     <= '0;
      kick      <= 1'b0;
      pend      <= 1'b0;
      prime_cnt <= 1'b0;
      ld_row    <= '0;
    end else begin
      kick <= 1'b0;
      done <= 1'b0;
      if (chain_go) pend <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_PRIME;
            busy      <= 1'b1;
            kick      <= 1'b1;
            pend      <= 1'b1;
            prime_cnt <= 1'b0;
            ld_row    <= '0;
            above     <= '0;
            win_x     <= '0;
            win_y     <= '0;
          end
        end
        S_PRIME: begin
          if (row_done) begin
            if (!prime_cnt) begin
              cur       <= row_out;
              prime_cnt <= 1'b1;
            end else begin
              below     <= row_out;
              state     <= S_EMIT;
              win_valid <= 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (win_ready) begin
            if (x_last) begin
              win_x     <= '0;
              win_valid <= 1'b0;
              if (y_last) begin
                state <= S_FINISH;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state  <= S_ADVANCE;
                // loader sees go during ADVANCE, reads start in LOAD
                kick   <= more_rows;
                ld_row <= ADDR_W'(win_y) + ADDR_W'(2);
              end
            end else begin
              win_x <= win_x + 1'b1;
            end
          end
        end
        S_ADVANCE: begin
          above <= cur;
          cur   <= below;
          win_y <= win_y + 1'b1;
          if (more_rows) begin
            state <= S_LOAD;
          end else begin
            below     <= '0;
            state     <= S_EMIT;
            win_valid <= 1'b1;
          end
        end
        S_LOAD: begin
          if (row_done) begin
            below     <= row_out;
            state     <= S_EMIT;
            win_valid <= 1'b1;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
